// File: rtl/exec_core_pipe.sv
// Two-stage (ID/EX) parametrised datapath core with valid/ready instruction intake.
// Define EXEC_CORE_FWD_EN to forward EX results into ID instead of stalling.
module exec_core_pipe #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 16,
  parameter int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic [2:0]        flags,
  output logic              busy
);

  localparam logic [3:0] OP_MVR = 4'h0;
  localparam logic [3:0] OP_LDB = 4'h1;
  localparam logic [3:0] OP_STB = 4'h2;
  localparam logic [3:0] OP_RDS = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_AND = 4'h9;
  localparam logic [3:0] OP_ORA = 4'hA;
  localparam logic [3:0] OP_ADD = 4'hB;
  localparam logic [3:0] OP_SUB = 4'hC;
  localparam logic [3:0] OP_XOR = 4'hD;
  localparam logic [3:0] OP_INC = 4'hE;
  localparam logic [3:0] OP_CMP = 4'hF;

  logic [DATA_W-1:0] rf_q [REG_COUNT];

  logic              ex_valid_q;
  logic [3:0]        ex_op_q;
  logic [DATA_W-1:0] ex_a_q;
  logic [DATA_W-1:0] ex_b_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [REG_AW-1:0] ex_dst_q;

  logic [DATA_W-1:0] data_out_q;
  logic              out_valid_q;
  logic [2:0]        flags_q;

  logic [DATA_W-1:0] ex_res;
  logic              ex_c;
  logic              ex_we;
  logic              ex_fw;
  logic              ex_out;
  logic [2:0]        flags_nx;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic [DATA_W:0]   inc;

  logic [REG_AW-1:0] id_dst;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;
  logic [2:0]        id_flags;
  logic              accept;

  // EX: result, carry and side-effect decode
  assign sum = {1'b0, ex_a_q} + {1'b0, ex_b_q};
  assign dif = {1'b0, ex_a_q} - {1'b0, ex_b_q};
  assign inc = {1'b0, ex_a_q} + (DATA_W+1)'(1);

  always_comb begin
    ex_res = ex_a_q;
    ex_c   = 1'b0;
    ex_we  = 1'b0;
    case (ex_op_q)
      OP_MVR: ex_we = 1'b1;
      OP_LDB: begin
        ex_res = ex_imm_q;
        ex_we  = 1'b1;
      end
      OP_NOT: begin
        ex_res = ~ex_a_q;
        ex_we  = 1'b1;
      end
      OP_AND: begin
        ex_res = ex_a_q & ex_b_q;
        ex_we  = 1'b1;
      end
      OP_ORA: begin
        ex_res = ex_a_q | ex_b_q;
        ex_we  = 1'b1;
      end
      OP_XOR: begin
        ex_res = ex_a_q ^ ex_b_q;
        ex_we  = 1'b1;
      end
      OP_ADD: begin
        ex_res = sum[DATA_W-1:0];
        ex_c   = sum[DATA_W];
        ex_we  = 1'b1;
      end
      OP_SUB: begin
        ex_res = dif[DATA_W-1:0];
        ex_c   = dif[DATA_W];
        ex_we  = 1'b1;
      end
      OP_CMP: begin
        ex_res = dif[DATA_W-1:0];
        ex_c   = dif[DATA_W];
      end
      OP_INC: begin
        ex_res = inc[DATA_W-1:0];
        ex_c   = inc[DATA_W];
        ex_we  = 1'b1;
      end
      default: ;
    endcase
  end

  assign ex_fw    = ex_op_q[3];
  assign ex_out   = (ex_op_q == OP_STB) || (ex_op_q == OP_RDS);
  assign flags_nx = ex_fw
                  ? {ex_res[DATA_W-1], ex_res == '0, ex_c}
                  : flags_q;

  // ID: destination select
  always_comb begin
    id_dst = rd;
    case (opcode)
      OP_MVR,
      OP_NOT: id_dst = rb;
      OP_LDB: id_dst = ra;
      default: ;
    endcase
  end

`ifdef EXEC_CORE_FWD_EN
  logic hit_a;
  logic hit_b;
  logic hit_f;

  assign hit_a = ex_valid_q && ex_we && (ex_dst_q == ra);
  assign hit_b = ex_valid_q && ex_we && (ex_dst_q == rb);
  assign hit_f = ex_valid_q && ex_fw;

  assign id_a        = hit_a ? ex_res : rf_q[ra];
  assign id_b        = hit_b ? ex_res : rf_q[rb];
  assign id_flags    = hit_f ? flags_nx : flags_q;
  assign instr_ready = !rst;
`else
  logic rd_a;
  logic rd_b;
  logic raw_haz;
  logic flg_haz;

  assign rd_a = (opcode == OP_MVR) || (opcode == OP_STB) || opcode[3];
  assign rd_b = opcode[3] && (opcode != OP_NOT) && (opcode != OP_INC);

  assign raw_haz = ex_valid_q && ex_we &&
                   ((rd_a && (ex_dst_q == ra)) ||
                    (rd_b && (ex_dst_q == rb)));
  assign flg_haz = ex_valid_q && ex_fw && (opcode == OP_RDS);

  assign id_a        = rf_q[ra];
  assign id_b        = rf_q[rb];
  assign id_flags    = flags_q;
  assign instr_ready = !rst && !(instr_valid && (raw_haz || flg_haz));
`endif

  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_dst_q    <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      ex_valid_q <= accept;
      if (accept) begin
        ex_op_q  <= opcode;
        // RDS carries the status word through the A operand slot
        ex_a_q   <= (opcode == OP_RDS)
                  ? {{(DATA_W-3){1'b0}}, id_flags}
                  : id_a;
        ex_b_q   <= id_b;
        ex_imm_q <= imm;
        ex_dst_q <= id_dst;
      end
      if (ex_valid_q && ex_we) rf_q[ex_dst_q] <= ex_res;
      if (ex_valid_q && ex_fw) flags_q <= flags_nx;
      out_valid_q <= ex_valid_q && ex_out;
      if (ex_valid_q && ex_out) data_out_q <= ex_a_q;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign flags     = flags_q;
  assign busy      = ex_valid_q;

endmodule

// File: tb/tb_exec_core_pipe.sv
// Directed bench for exec_core_pipe: default 8x16 core plus a 16-bit, 32-register core.
module tb_exec_core_pipe;

`ifdef EXEC_CORE_FWD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v0 = 1'b0;
  logic        v1 = 1'b0;
  logic [3:0]  op = '0;
  logic [4:0]  ra = '0;
  logic [4:0]  rb = '0;
  logic [4:0]  rd = '0;
  logic [15:0] imm = '0;

  logic        rdy0, rdy1;
  logic [7:0]  dout0;
  logic [15:0] dout1;
  logic        ov0, ov1;
  logic [2:0]  fl0, fl1;
  logic        busy0, busy1;

  int n_chk  = 0;
  int n_fail = 0;
  int last_stall;

  always #5 clk = ~clk;

  exec_core_pipe u0 (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (v0),
    .instr_ready (rdy0),
    .opcode      (op),
    .ra          (ra[3:0]),
    .rb          (rb[3:0]),
    .rd          (rd[3:0]),
    .imm         (imm[7:0]),
    .data_out    (dout0),
    .out_valid   (ov0),
    .flags       (fl0),
    .busy        (busy0)
  );

  exec_core_pipe #(.DATA_W(16), .REG_COUNT(32)) u1 (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (v1),
    .instr_ready (rdy1),
    .opcode      (op),
    .ra          (ra),
    .rb          (rb),
    .rd          (rd),
    .imm         (imm),
    .data_out    (dout1),
    .out_valid   (ov1),
    .flags       (fl1),
    .busy        (busy1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit sel, input logic [3:0] o,
                       input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic [15:0] im);
    int n;
    @(negedge clk);
    op  = o;
    ra  = a;
    rb  = b;
    rd  = d;
    imm = im;
    v0  = !sel;
    v1  = sel;
    #1;
    n = 0;
    while (!(sel ? rdy1 : rdy0) && n < 4) begin
      @(negedge clk);
      #1;
      n++;
    end
    last_stall = n;
    if (n == 4) check("ready_timeout", 32'(0), 32'(1));
    @(posedge clk);
    #1;
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic store(input bit sel, input logic [3:0] o,
                       input logic [4:0] a, input string tag,
                       input logic [15:0] exp);
    issue(sel, o, a, 5'd0, 5'd0, 16'h0);
    tick();
    check({tag, "_ov"}, 32'(sel ? ov1 : ov0), 32'(1));
    check(tag, 32'(sel ? dout1 : {8'h0, dout0}), 32'(exp));
    tick();
    check({tag, "_ov_clr"}, 32'(sel ? ov1 : ov0), 32'(0));
  endtask

  task automatic flg(input string tag, input logic [2:0] exp);
    tick();
    check(tag, 32'(fl0), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    v0 = 1'b1;
    #1;
    check("rst_ready", 32'(rdy0), 32'(0));
    check("rst_flags", 32'(fl0), 32'(0));
    check("rst_dout", 32'(dout0), 32'(0));
    check("rst_ov", 32'(ov0), 32'(0));
    check("rst_busy", 32'(busy0), 32'(0));
    v0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    issue(0, 4'h1, 5'd1, 5'd0, 5'd0, 16'h05);
    check("busy_ldb", 32'(busy0), 32'(1));
    issue(0, 4'h1, 5'd2, 5'd0, 5'd0, 16'hFB);
    issue(0, 4'hB, 5'd1, 5'd2, 5'd3, 16'h0);
    store(0, 4'h2, 5'd3, "add_res", 16'h00);
    store(0, 4'h3, 5'd0, "rds_add", 16'h03);

    issue(0, 4'h1, 5'd4, 5'd0, 5'd0, 16'h03);
    issue(0, 4'h1, 5'd5, 5'd0, 5'd0, 16'h07);
    issue(0, 4'hC, 5'd4, 5'd5, 5'd6, 16'h0);
    flg("sub_flags", 3'b101);
    store(0, 4'h2, 5'd6, "sub_res", 16'hFC);
    issue(0, 4'hF, 5'd5, 5'd5, 5'd6, 16'h0);
    store(0, 4'h3, 5'd0, "rds_cmp", 16'h02);
    store(0, 4'h2, 5'd6, "cmp_nowr", 16'hFC);

    issue(0, 4'h1, 5'd7, 5'd0, 5'd0, 16'hFF);
    issue(0, 4'hE, 5'd7, 5'd0, 5'd8, 16'h0);
    flg("inc_ff_flags", 3'b011);
    store(0, 4'h2, 5'd8, "inc_ff", 16'h00);
    issue(0, 4'h1, 5'd9, 5'd0, 5'd0, 16'h7F);
    issue(0, 4'hE, 5'd9, 5'd0, 5'd10, 16'h0);
    flg("inc_7f_flags", 3'b100);
    store(0, 4'h2, 5'd10, "inc_7f", 16'h80);

    issue(0, 4'h5, 5'd1, 5'd2, 5'd3, 16'h0);
    tick();
    check("nop_flags", 32'(fl0), 32'(3'b100));
    check("nop_ov", 32'(ov0), 32'(0));

    issue(0, 4'h1, 5'd1, 5'd0, 5'd0, 16'h10);
    issue(0, 4'hB, 5'd1, 5'd1, 5'd2, 16'h0);
    check("b2b_add_stall", 32'(last_stall), 32'(EXP_STALL));
    issue(0, 4'h2, 5'd2, 5'd0, 5'd0, 16'h0);
    check("b2b_stb_stall", 32'(last_stall), 32'(EXP_STALL));
    tick();
    check("b2b_res", 32'(dout0), 32'(16'h20));

    issue(0, 4'h0, 5'd1, 5'd12, 5'd0, 16'h0);
    store(0, 4'h2, 5'd12, "mvr", 16'h10);
    issue(0, 4'h8, 5'd12, 5'd13, 5'd0, 16'h0);
    flg("not_flags", 3'b100);
    store(0, 4'h2, 5'd13, "not", 16'hEF);
    issue(0, 4'h9, 5'd12, 5'd13, 5'd14, 16'h0);
    flg("and_flags", 3'b010);
    issue(0, 4'hD, 5'd12, 5'd13, 5'd15, 16'h0);
    store(0, 4'h2, 5'd15, "xor", 16'hFF);
    issue(0, 4'hA, 5'd1, 5'd2, 5'd11, 16'h0);
    store(0, 4'h2, 5'd11, "ora", 16'h30);
    issue(0, 4'h1, 5'd0, 5'd0, 5'd0, 16'h5A);
    store(0, 4'h2, 5'd0, "r0_wr", 16'h5A);

    issue(0, 4'hB, 5'd1, 5'd2, 5'd4, 16'h0);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(rdy0), 32'(0));
    check("mid_rst_busy", 32'(busy0), 32'(0));
    tick();
    check("mid_rst_flags", 32'(fl0), 32'(0));
    check("mid_rst_ov", 32'(ov0), 32'(0));
    check("mid_rst_ready2", 32'(rdy0), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(rdy0), 32'(1));
    store(0, 4'h2, 5'd4, "mid_rst_dst", 16'h00);

    issue(1, 4'h1, 5'd31, 5'd0, 5'd0, 16'hFFFF);
    issue(1, 4'hB, 5'd31, 5'd31, 5'd0, 16'h0);
    tick();
    check("w16_flags", 32'(fl1), 32'(3'b101));
    store(1, 4'h2, 5'd0, "w16_add", 16'hFFFE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
